// File: rtl/traffic_pkg.sv
// traffic_pkg: constants shared by the traffic generator, player control and renderer.
// Lane geometry, per-lane motion constants and the default move-interval timing.
package traffic_pkg;

    // Display and car geometry
    localparam int H_DISPLAY = 640;
    localparam int CAR_WIDTH = 32;
    localparam int CAR_Y1    = 96;
    localparam int CAR_Y2    = 160;
    localparam int CAR_Y3    = 224;
    localparam int CAR_Y4    = 288;
    localparam int CAR_Y5    = 352;
    localparam int CAR_Y6    = 416;

    localparam int NUM_LANES = 6;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } lane_dir_e;

    // Per-lane seed position, pixels moved per interval and direction
    localparam logic [9:0] LANE_INIT_X [NUM_LANES] = '{10'd0, 10'd320, 10'd96, 10'd480, 10'd192, 10'd560};
    localparam int         LANE_STEP   [NUM_LANES] = '{2, 3, 4, 2, 3, 4};
    localparam lane_dir_e  LANE_DIR    [NUM_LANES] = '{DIR_RIGHT, DIR_LEFT, DIR_RIGHT,
                                                       DIR_LEFT,  DIR_RIGHT, DIR_LEFT};

    // Default timing, in clock cycles
    localparam int unsigned DEF_BASE_PERIOD = 32'd2_000_000;
    localparam int unsigned DEF_LEVEL_STEP  = 32'd150_000;
    localparam int unsigned DEF_MIN_PERIOD  = 32'd400_000;

endpackage

// File: rtl/traffic_if.sv
// traffic_if: control inputs and car positions of the traffic generator.
// master = the controlling side, slave = traffic_generator itself.
interface traffic_if;
    logic [3:0] LEVEL;
    logic       PAUSE;
    logic       RESTART;
    logic [9:0] car_x1;
    logic [9:0] car_x2;
    logic [9:0] car_x3;
    logic [9:0] car_x4;
    logic [9:0] car_x5;
    logic [9:0] car_x6;

    modport master (
        output LEVEL, PAUSE, RESTART,
        input  car_x1, car_x2, car_x3, car_x4, car_x5, car_x6
    );

    modport slave (
        input  LEVEL, PAUSE, RESTART,
        output car_x1, car_x2, car_x3, car_x4, car_x5, car_x6
    );
endinterface

// File: rtl/lane_mover.sv
// lane_mover: one road lane -- interval counter, wrap arithmetic and the
// registered left-edge x position. Priority: restart > pause > counting.
module lane_mover
    import traffic_pkg::*;
#(
    parameter logic [9:0] INIT_X = 10'd0,
    parameter int         STEP   = 1,
    parameter lane_dir_e  DIR    = DIR_RIGHT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        restart,
    input  logic        pause,
    input  logic [31:0] period,
    output logic        wrap,
    output logic [9:0]  pos
);

    localparam logic [10:0] H_W    = 11'(H_DISPLAY);
    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [31:0] cnt;

    // One extra bit keeps x+step from overflowing before the modulo fold.
    function automatic logic [9:0] next_x(input logic [9:0] x);
        logic [10:0] xw;
        xw = {1'b0, x};
        if (DIR == DIR_RIGHT)
            return 10'((xw + STEP_W >= H_W) ? (xw + STEP_W - H_W) : (xw + STEP_W));
        else
            return 10'((xw < STEP_W) ? (xw + H_W - STEP_W) : (xw - STEP_W));
    endfunction

    assign wrap = (cnt == period - 32'd1);

    // Interval counter and position register; the lane moves on the wrap cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            pos <= INIT_X;
        end else if (restart) begin
            cnt <= '0;
            pos <= INIT_X;
        end else if (!pause) begin
            if (wrap) begin
                cnt <= '0;
                pos <= next_x(pos);
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_generator.sv
// traffic_generator: six independently stepping road cars sharing one latched
// move period. Optional macro TRAFFIC_LEVEL_EN ties the period to LEVEL; without
// it the period is fixed at BASE_PERIOD and LEVEL is ignored.
module traffic_generator
    import traffic_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD
) (
    input  logic     CLK,
    input  logic     RST_N,
    traffic_if.slave bus
);

    logic [31:0] period_q;
    logic [31:0] p_new;
    logic [5:0]  lane_wrap;
    logic [9:0]  lane_pos [NUM_LANES];

`ifdef TRAFFIC_LEVEL_EN
    // Unsigned throughout: the clamp is decided before subtracting, so the
    // subtraction can never go negative.
    function automatic logic [31:0] calc_period(input logic [3:0] lvl);
        logic [31:0] dec;
        dec = 32'(lvl) * 32'(LEVEL_STEP);
        if (dec >= 32'(BASE_PERIOD) - 32'(MIN_PERIOD))
            return 32'(MIN_PERIOD);
        return 32'(BASE_PERIOD) - dec;
    endfunction

    assign p_new = calc_period(bus.LEVEL);
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = {28'd0, bus.LEVEL} ^ 32'(LEVEL_STEP) ^ 32'(MIN_PERIOD);
    assign p_new      = 32'(BASE_PERIOD);
`endif

    // Period changes only at a lane 1 interval boundary (or restart), so an
    // interval already in progress always runs its full length.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            period_q <= 32'(BASE_PERIOD);
        else if (bus.RESTART)
            period_q <= p_new;
        else if (!bus.PAUSE && lane_wrap[0])
            period_q <= p_new;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_mover #(
            .INIT_X (LANE_INIT_X[i]),
            .STEP   (LANE_STEP[i]),
            .DIR    (LANE_DIR[i])
        ) u_lane (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .restart (bus.RESTART),
            .pause   (bus.PAUSE),
            .period  (period_q),
            .wrap    (lane_wrap[i]),
            .pos     (lane_pos[i])
        );
    end

    // All lanes share period_q and counter phase, so only lane 1 paces the latch.
    logic unused_wrap;
    assign unused_wrap = ^lane_wrap[5:1];

    assign bus.car_x1 = lane_pos[0];
    assign bus.car_x2 = lane_pos[1];
    assign bus.car_x3 = lane_pos[2];
    assign bus.car_x4 = lane_pos[3];
    assign bus.car_x5 = lane_pos[4];
    assign bus.car_x6 = lane_pos[5];

endmodule

// File: tb/tb_traffic_generator.sv
// tb_traffic_generator: directed scenarios against traffic_generator with
// BASE_PERIOD=10, LEVEL_STEP=2, MIN_PERIOD=4. Expected positions come from a
// closed-form model (seed + direction*step*moves mod 640) queued per check.
module tb_traffic_generator;

    logic CLK = 1'b0;
    logic RST_N;

    traffic_if bus();

    traffic_generator #(
        .BASE_PERIOD (10),
        .LEVEL_STEP  (2),
        .MIN_PERIOD  (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam int INIT [6] = '{0, 320, 96, 480, 192, 560};
    localparam int STP  [6] = '{2, 3, 4, 2, 3, 4};
    localparam int SGN  [6] = '{1, -1, 1, -1, 1, -1};

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    int m_moves;
    int m_cnt;
    int m_period;

    function automatic int p_new(input int lvl);
`ifdef TRAFFIC_LEVEL_EN
        if (lvl * 2 >= 10 - 4) return 4;
        return 10 - lvl * 2;
`else
        return 10 + 0 * lvl;
`endif
    endfunction

    function automatic int model_x(input int i);
        int v;
        v = (INIT[i] + SGN[i] * STP[i] * m_moves) % 640;
        if (v < 0) v += 640;
        return v;
    endfunction

    function automatic logic [31:0] dut_x(input int i);
        case (i)
            0:       return {22'd0, bus.car_x1};
            1:       return {22'd0, bus.car_x2};
            2:       return {22'd0, bus.car_x3};
            3:       return {22'd0, bus.car_x4};
            4:       return {22'd0, bus.car_x5};
            default: return {22'd0, bus.car_x6};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_moves  = 0;
        m_cnt    = 0;
        m_period = 10;
    endtask

    // Advance the model with the inputs present at the edge, then step the DUT.
    task automatic tick(input int n);
        repeat (n) begin
            if (RST_N) begin
                if (bus.RESTART) begin
                    m_moves  = 0;
                    m_cnt    = 0;
                    m_period = p_new(int'(bus.LEVEL));
                end else if (!bus.PAUSE) begin
                    if (m_cnt == m_period - 1) begin
                        m_cnt    = 0;
                        m_moves++;
                        m_period = p_new(int'(bus.LEVEL));
                    end else begin
                        m_cnt++;
                    end
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 6; i++) exp_q.push_back(model_x(i));
        for (int i = 0; i < 6; i++) begin
            int e;
            e = exp_q.pop_front();
            check($sformatf("%s.car_x%0d", tag, i + 1), dut_x(i), e);
        end
    endtask

    task automatic check_seed(input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s.seed%0d", tag, i + 1), dut_x(i), INIT[i]);
    endtask

    initial begin
        RST_N       = 1'b0;
        bus.LEVEL   = 4'd0;
        bus.PAUSE   = 1'b0;
        bus.RESTART = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_seed("reset");
        RST_N = 1'b1;

        // 1: first move lands on the 10th edge after release
        tick(9);
        check("s1.x1_before", dut_x(0), 0);
        tick(1);
        check("s1.x1", dut_x(0), 2);
        check("s1.x2", dut_x(1), 317);
        check("s1.x3", dut_x(2), 100);
        check_model("s1");

        // 2: long run through both wrap directions
        tick(2390);
        check("s2.x4_240", dut_x(3), 0);
        tick(10);
        check("s2.x4_241", dut_x(3), 638);
        check_model("s2.m241");
        tick(780);
        check("s2.x1_319", dut_x(0), 638);
        tick(10);
        check("s2.x1_320", dut_x(0), 0);
        check_model("s2.m320");

`ifdef TRAFFIC_LEVEL_EN
        // 3: level changes only take effect at the next interval
        tick(3);
        bus.LEVEL = 4'd3;
        tick(6);
        check("s3.lvl3_hold", dut_x(0), 0);
        tick(1);
        check("s3.lvl3_full", dut_x(0), 2);
        tick(3);
        check("s3.p4_wait", dut_x(0), 2);
        tick(1);
        check("s3.p4_move", dut_x(0), 4);
        bus.LEVEL = 4'd5;
        tick(4);
        check("s3.lvl5_a", dut_x(0), 6);
        tick(3);
        check("s3.clamp_wait", dut_x(0), 6);
        tick(1);
        check("s3.clamp_move", dut_x(0), 8);
        bus.LEVEL = 4'd2;
        tick(4);
        check("s3.lvl2_old", dut_x(0), 10);
        tick(5);
        check("s3.p6_wait", dut_x(0), 10);
        tick(1);
        check("s3.p6_move", dut_x(0), 12);
        check_model("s3");
`else
        // 6: LEVEL ignored, period fixed at 10
        bus.LEVEL = 4'd7;
        tick(9);
        check("s6.wait1", dut_x(0), 0);
        tick(1);
        check("s6.move1", dut_x(0), 2);
        tick(9);
        check("s6.wait2", dut_x(0), 2);
        tick(1);
        check("s6.move2", dut_x(0), 4);
        check_model("s6");
`endif

        // 4: pause holds everything; restart wins over pause
        bus.LEVEL = 4'd0;
        tick(3);
        check_model("s4.pre");
        bus.PAUSE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(10);
            check_model($sformatf("s4.pause%0d", k));
        end
        bus.RESTART = 1'b1;
        tick(1);
        bus.RESTART = 1'b0;
        check_seed("s4.restart");
        bus.PAUSE = 1'b0;
        tick(9);
        check("s4.x1_wait", dut_x(0), 0);
        tick(1);
        check("s4.x1_move", dut_x(0), 2);
        check("s4.x2_move", dut_x(1), 317);
        check_model("s4.post");

        // 5: asynchronous reset mid-interval
        tick(7);
        RST_N = 1'b0;
        #1;
        check_seed("s5.async");
        model_reset();
        tick(2);
        check_seed("s5.hold");
        RST_N = 1'b1;
        tick(9);
        check("s5.x1_wait", dut_x(0), 0);
        tick(1);
        check("s5.x1_move", dut_x(0), 2);
        check_model("s5.post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
